// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - two-channel button synchronizer, debouncer and press/release/long-press strobe generator
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_0,
  input  logic       button_1,
  output logic [1:0] btn_level,
  output logic [1:0] btn_press,
  output logic [1:0] btn_release,
  output logic [1:0] btn_long
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_CHK_PRESS,
    ST_PRESSED,
    ST_CHK_RELEASE
  } state_e;

  logic [1:0] raw;
  assign raw = {button_1, button_0};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          pressed;

    always_comb begin
      sync1_d   = raw[g];
      sync2_d   = sync1_q;
      pressed   = ~sync2_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;

      case (state_q)
        ST_RELEASED: begin
          if (pressed) begin
            state_d = ST_CHK_PRESS;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d   = '0;
          end
        end
        ST_CHK_PRESS: begin
          if (!pressed) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = ST_PRESSED;
            press_d = 1'b1;
            hold_d  = '0;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          // Saturating hold count; the long strobe marks only the step onto the limit.
          if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_ONE;
            long_d = (hold_q == HOLD_LAST);
          end
          if (!pressed) begin
            state_d = ST_CHK_RELEASE;
            cnt_d   = CNT_ONE;
          end
        end
        ST_CHK_RELEASE: begin
          if (pressed) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d   = ST_RELEASED;
            release_d = 1'b1;
            hold_d    = '0;
            cnt_d     = '0;
          end else begin
            cnt_d     = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
          hold_d  = '0;
        end
      endcase

      level_d = (state_d == ST_PRESSED) || (state_d == ST_CHK_RELEASE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q   <= 1'b1;
        sync2_q   <= 1'b1;
        state_q   <= ST_RELEASED;
        cnt_q     <= '0;
        hold_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        hold_q    <= hold_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
      end
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
    assign btn_long[g]    = long_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed checks of button_conditioner with default parameters
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic       button_0;
  logic       button_1;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_long;

  int tests_run;
  int tests_failed;

  button_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button_0   (button_0),
    .button_1   (button_1),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp packs {level, press, release, long}; for phases the strobe fields mean "seen during the phase".
  typedef struct {
    string      name;
    logic [1:0] b;
    int         n;
    logic [7:0] exp;
  } phase_t;

  phase_t tbl[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int cyc, input logic [7:0] exp);
    logic [7:0] act;
    act = {btn_level, btn_press, btn_release, btn_long};
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got lvl/prs/rel/lng=%b expected %b", name, cyc, act, exp);
    end
  endtask

  // Drive both buttons, then check every cycle; *_at are 1-based step indices, 0 = never.
  task automatic seq(input string name, input logic [1:0] b, input int n, input logic [1:0] ch,
                     input int press_at, input int long_at, input int rel_at, input logic lvl0);
    logic       lvl;
    logic [7:0] exp;
    button_0 = b[0];
    button_1 = b[1];
    for (int i = 1; i <= n; i++) begin
      step();
      lvl = lvl0;
      if (press_at != 0 && i >= press_at) lvl = 1'b1;
      if (rel_at != 0 && i >= rel_at) lvl = 1'b0;
      exp = {(lvl ? ch : 2'b00),
             ((i == press_at) ? ch : 2'b00),
             ((i == rel_at) ? ch : 2'b00),
             ((i == long_at) ? ch : 2'b00)};
      check(name, i, exp);
    end
  endtask

  initial begin
    logic [1:0] sp, sr, sl;
    tests_run    = 0;
    tests_failed = 0;

    tbl[0]  = '{"idle",     2'b11, 10, 8'b00_00_00_00};
    tbl[1]  = '{"glitch_a", 2'b10,  3, 8'b00_00_00_00};
    tbl[2]  = '{"glitch_h", 2'b11,  1, 8'b00_00_00_00};
    tbl[3]  = '{"glitch_b", 2'b10,  3, 8'b00_00_00_00};
    tbl[4]  = '{"glitch_s", 2'b11, 10, 8'b00_00_00_00};
    tbl[5]  = '{"short_dn", 2'b10, 10, 8'b01_01_00_00};
    tbl[6]  = '{"short_up", 2'b11, 20, 8'b00_00_01_00};
    tbl[7]  = '{"bnc_dn",   2'b10, 12, 8'b01_01_00_00};
    tbl[8]  = '{"bnc_hi",   2'b11,  2, 8'b01_00_00_00};
    tbl[9]  = '{"bnc_lo",   2'b10,  5, 8'b01_00_00_00};
    tbl[10] = '{"bnc_up",   2'b11, 10, 8'b00_00_01_00};
    tbl[11] = '{"sim_dn",   2'b00,  8, 8'b11_11_00_00};
    tbl[12] = '{"stag_0",   2'b01,  8, 8'b10_00_01_00};
    tbl[13] = '{"stag_1",   2'b11,  8, 8'b00_00_10_00};

    // Reset with both buttons held, then both must debounce together.
    rst_n    = 1'b0;
    button_0 = 1'b0;
    button_1 = 1'b0;
    #1;
    check("reset_t0", 0, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("reset_hold", i, 8'h00);
    end
    rst_n = 1'b1;
    seq("rst_both_press", 2'b00, 10, 2'b11, 7, 0, 0, 1'b0);
    seq("both_release",   2'b11, 10, 2'b11, 0, 0, 7, 1'b1);

    for (int p = 0; p < 14; p++) begin
      button_0 = tbl[p].b[0];
      button_1 = tbl[p].b[1];
      sp = 2'b00;
      sr = 2'b00;
      sl = 2'b00;
      for (int i = 0; i < tbl[p].n; i++) begin
        step();
        sp |= btn_press;
        sr |= btn_release;
        sl |= btn_long;
      end
      tests_run++;
      if ({btn_level, sp, sr, sl} !== tbl[p].exp) begin
        tests_failed++;
        $display("FAIL phase %s: got lvl/prs/rel/lng=%b expected %b",
                 tbl[p].name, {btn_level, sp, sr, sl}, tbl[p].exp);
      end
    end

    // Clean long press on button_1; channel 0 must stay silent.
    seq("b1_hold",    2'b01, 50, 2'b10, 7, 39, 0, 1'b0);
    seq("b1_release", 2'b11, 12, 2'b10, 0, 0, 7, 1'b1);

    // Reset at hold=20 with button_0 still held, then a fresh press and long count.
    seq("b0_pre_reset", 2'b10, 27, 2'b01, 7, 0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("reset_async", 0, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("reset_mid", i, 8'h00);
    end
    rst_n = 1'b1;
    seq("b0_repress", 2'b10, 45, 2'b01, 7, 39, 0, 1'b0);
    seq("b0_release", 2'b11, 12, 2'b01, 0, 0, 7, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-conditioning stage directly upstream of the LED `control` block.
- Takes the two raw, asynchronous, active-low board buttons and produces clean, clock-domain-safe events for `control` to consume.
- Per channel: a 2-flop synchronizer, a counter-based debouncer, single-cycle press/release strobes and a one-shot long-press strobe.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to commit a level change. Legal range is 1 or more. Board builds override this to about 200000.
- LONG_PRESS_CYCLES, 32: cycles spent in PRESSED before btn_long fires. Must be greater than 0.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low. Asserts immediately, releases on the clock.
- button_0  in  1  raw button 0, active-low (1 = released), asynchronous.
- button_1  in  1  raw button 1, active-low (1 = released), asynchronous.
- btn_level  out  2  debounced level, active-high (1 = pressed). Bit i corresponds to button_i.
- btn_press  out  2  one-cycle strobe on a committed press.
- btn_release  out  2  one-cycle strobe on a committed release.
- btn_long  out  2  one-cycle strobe when a press has been held LONG_PRESS_CYCLES.

Behaviour:
- Two identical, independent channels. Bit i of every output belongs to button_i.
- Reset state (rst_n=0, asynchronous):
  - Synchronizer flops = 1 (released).
  - FSM = RELEASED; all counters = 0.
  - btn_level = btn_press = btn_release = btn_long = 2'b00.
- Synchronizer: s1 <= raw; s2 <= s1. Only s2 feeds the FSM. Define p = ~s2 (1 = pressed).
- Counters:
  - Debounce counter width: $clog2(DEBOUNCE_CYCLES+1).
  - Hold counter width: $clog2(LONG_PRESS_CYCLES+1); it saturates.
- FSM states per channel: RELEASED, CHK_PRESS, PRESSED, CHK_RELEASE.
- RELEASED:
  - p=1: go to CHK_PRESS, cnt=1.
  - Otherwise stay, cnt=0.
- CHK_PRESS:
  - p=0: return to RELEASED, cnt=0. Any glitch aborts.
  - p=1 and cnt==DEBOUNCE_CYCLES: go to PRESSED, btn_press=1 for this one cycle, hold=0.
  - p=1 otherwise: cnt+1.
- PRESSED:
  - btn_level=1.
  - hold increments each cycle and saturates at LONG_PRESS_CYCLES.
  - btn_long=1 in exactly the cycle hold transitions to LONG_PRESS_CYCLES. It fires once per press and never repeats.
  - p=0: go to CHK_RELEASE, cnt=1; hold freezes.
- CHK_RELEASE:
  - btn_level stays 1.
  - p=1: return to PRESSED, cnt=0; hold resumes from its frozen value.
  - p=0 and cnt==DEBOUNCE_CYCLES: go to RELEASED, btn_release=1 for one cycle, btn_level=0, hold=0.
  - p=0 otherwise: cnt+1.
- btn_level is registered and equals 1 exactly in PRESSED and CHK_RELEASE.
- Strobes are registered outputs. btn_press rises in the same cycle btn_level rises. btn_release rises in the same cycle btn_level falls.
- Latency, from the first rising edge that samples raw low to btn_press high: exactly DEBOUNCE_CYCLES+2 cycles. Release latency is identical.
- A pulse shorter than DEBOUNCE_CYCLES synchronized cycles produces no outputs.
- btn_press, btn_release and btn_long are mutually exclusive within a channel in any cycle.
- Both channels may strobe in the same cycle; no arbitration is performed.
- Reset mid-press: outputs clear immediately. After release, a still-held button must be re-debounced and produces a fresh btn_press.
- DEBOUNCE_CYCLES=1 is legal: commit on the first stable sample after entering CHK_*.

Test Plan:
- Reset: rst_n=0 for 3 cycles with both buttons held low -> all outputs 0 during reset. After release, btn_press for both channels occurs 6 cycles after the first post-reset edge (defaults).
- Clean press, 10 ns clock: button_1 driven 1→0 for 50 cycles then back to 1 -> btn_press[1] one cycle, 6 cycles after the first low sample. btn_long[1] one cycle, 32 cycles after btn_press[1]. btn_release[1] one cycle, 6 cycles after the first high sample. Channel 0 stays silent throughout.
- Glitch rejection: button_0 low for 3 cycles, high 1 cycle, low 3 cycles -> no strobes and btn_level[0]=0 throughout. A release bounce of 2 cycles while pressed -> no btn_release and btn_level stays 1.
- Short press: button_0 low for 10 cycles -> btn_press[0] and btn_release[0] fire; btn_long[0] never fires.
- Simultaneous: both buttons fall on the same edge -> btn_press=2'b11 in a single cycle. Staggered releases produce independent strobes.
- Reset mid-hold: assert rst_n while PRESSED with hold=20, keep button_0 low, release rst_n -> outputs 0 during reset, a new btn_press[0] after 6 cycles, and btn_long[0] at hold=32 counted from that new press.
